// File: rtl/multi_rate_divider_pkg.sv
// Shared game constants: tick channel mode encodings and the standard refresh/jump periods.
package multi_rate_divider_pkg;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } mode_e;

  localparam int FRAME_PERIOD = 1000001;
  localparam int JUMP_PERIOD  = 10001;

endpackage

// File: rtl/multi_rate_divider_tick_channel.sv
// One programmable down-counting enable channel: shadow period/mode, count, running and tick.
module tick_channel
  import multi_rate_divider_pkg::*;
#(
  parameter int               WIDTH        = 27,
  parameter logic [WIDTH-1:0] RESET_PERIOD = WIDTH'(FRAME_PERIOD),
  parameter logic             RESET_RUN    = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_period,
  input  logic             load_oneshot,
  output logic             tick,
  output logic             running
);

  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] next_period;
  logic [WIDTH-1:0] count;
  mode_e            mode;
  mode_e            next_mode;

  // Period 0 is treated as 1, so both reload to a count of 0.
  function automatic logic [WIDTH-1:0] reload_value(input logic [WIDTH-1:0] p);
    return (p == '0) ? '0 : p - WIDTH'(1);
  endfunction

  // A write on the same edge as a start or reload is already visible to it.
  always_comb begin
    next_period = period;
    next_mode   = mode;
    if (load) begin
      next_period = load_period;
      next_mode   = load_oneshot ? MODE_ONESHOT : MODE_PERIODIC;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick    <= 1'b0;
      period  <= RESET_PERIOD;
      mode    <= MODE_PERIODIC;
      running <= RESET_RUN;
      count   <= reload_value(RESET_PERIOD);
    end else begin
      period <= next_period;
      mode   <= next_mode;
      if (stop) begin
        running <= 1'b0;
        tick    <= 1'b0;
      end else if (start) begin
        running <= 1'b1;
        tick    <= 1'b0;
        count   <= reload_value(next_period);
      end else if (running) begin
        if (count == '0) begin
          tick <= 1'b1;
          if (mode == MODE_ONESHOT) running <= 1'b0;
          else                      count   <= reload_value(next_period);
        end else begin
          count <= count - WIDTH'(1);
          tick  <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/multi_rate_divider.sv
// CH independent tick channels; decodes the period/mode write onto one channel.
module multi_rate_divider
  import multi_rate_divider_pkg::*;
#(
  parameter int                  CH              = 2,
  parameter int                  WIDTH           = 27,
  parameter logic [CH*WIDTH-1:0] DEFAULT_PERIODS = {WIDTH'(JUMP_PERIOD), WIDTH'(FRAME_PERIOD)},
  parameter logic [CH-1:0]       RUN_AT_RESET    = {CH{1'b1}},
  localparam int                 LCW             = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CH-1:0]    start,
  input  logic [CH-1:0]    stop,
  input  logic             load_valid,
  input  logic [LCW-1:0]   load_ch,
  input  logic [WIDTH-1:0] load_period,
  input  logic             load_oneshot,
  output logic [CH-1:0]    tick,
  output logic [CH-1:0]    running
);

  logic [CH-1:0] load_hit;

  // Out-of-range channel numbers match no instance, so the write is dropped.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign load_hit[i] = load_valid && (int'(load_ch) == i);

    tick_channel #(
      .WIDTH       (WIDTH),
      .RESET_PERIOD(DEFAULT_PERIODS[i*WIDTH +: WIDTH]),
      .RESET_RUN   (RUN_AT_RESET[i])
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .start       (start[i]),
      .stop        (stop[i]),
      .load        (load_hit[i]),
      .load_period (load_period),
      .load_oneshot(load_oneshot),
      .tick        (tick[i]),
      .running     (running[i])
    );
  end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed bench for multi_rate_divider: per-edge tick/running logs compared against hand-derived patterns.
module tb_multi_rate_divider;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] start, stop;
  logic       load_valid, load_ch, load_oneshot;
  logic [7:0] load_period;
  logic [1:0] tick, running;

  logic [2:0] start3, stop3;
  logic       load_valid3, load_oneshot3;
  logic [1:0] load_ch3;
  logic [7:0] load_period3;
  logic [2:0] tick3, running3;

  int n_checks = 0;
  int n_fail   = 0;
  int ecount   = 0;
  int e0, s, t;

  logic [2:0] tick_log  [0:1023];
  logic [2:0] run_log   [0:1023];
  logic [2:0] tick3_log [0:1023];
  logic [2:0] run3_log  [0:1023];

  always #5 clock = ~clock;

  multi_rate_divider #(
    .CH(2), .WIDTH(8), .DEFAULT_PERIODS({8'd6, 8'd4}), .RUN_AT_RESET(2'b11)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .load_valid(load_valid), .load_ch(load_ch), .load_period(load_period),
    .load_oneshot(load_oneshot), .tick(tick), .running(running)
  );

  multi_rate_divider #(
    .CH(3), .WIDTH(8), .DEFAULT_PERIODS({8'd3, 8'd4, 8'd5}), .RUN_AT_RESET(3'b000)
  ) dut3 (
    .clock(clock), .reset(reset), .start(start3), .stop(stop3),
    .load_valid(load_valid3), .load_ch(load_ch3), .load_period(load_period3),
    .load_oneshot(load_oneshot3), .tick(tick3), .running(running3)
  );

  always @(posedge clock) ecount <= ecount + 1;

  // Entry k holds the outputs during the cycle after edge k.
  always @(negedge clock) begin
    tick_log[ecount]  <= {1'b0, tick};
    run_log[ecount]   <= {1'b0, running};
    tick3_log[ecount] <= tick3;
    run3_log[ecount]  <= running3;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // sel: 0 tick, 1 running, 2 tick3, 3 running3
  function automatic logic [31:0] pat(input int sel, input int ch, input int base, input int len);
    logic [31:0] r = '0;
    for (int k = 0; k < len; k++) begin
      case (sel)
        0:       r[k] = tick_log[base+k][ch];
        1:       r[k] = run_log[base+k][ch];
        2:       r[k] = tick3_log[base+k][ch];
        default: r[k] = run3_log[base+k][ch];
      endcase
    end
    return r;
  endfunction

  initial begin
    reset = 1'b1;
    start = '0; stop = '0; load_valid = 1'b0; load_ch = 1'b0; load_oneshot = 1'b0; load_period = '0;
    start3 = '0; stop3 = '0; load_valid3 = 1'b0; load_ch3 = '0; load_oneshot3 = 1'b0; load_period3 = '0;

    // Reset defaults and free-running ticks
    cyc(2);
    check_eq("reset_tick", 32'(tick), 32'h0);
    check_eq("reset_running", 32'(running), 32'h3);
    check_eq("reset_running3", 32'(running3), 32'h0);
    reset = 1'b0;
    e0 = ecount;
    cyc(16);
    check_eq("free_ch0", pat(0, 0, e0, 16), 32'h1110);
    check_eq("free_ch1", pat(0, 1, e0, 16), 32'h1040);
    check_eq("free_running", 32'(running), 32'h3);

    // Out-of-range load with simultaneous start on the 3-channel instance
    load_valid3 = 1'b1; load_ch3 = 2'd3; load_period3 = 8'd1; start3 = 3'b111;
    s = ecount + 1;
    cyc(1);
    load_valid3 = 1'b0; start3 = '0;
    cyc(6);
    check_eq("oor_ch0", pat(2, 0, s, 6), 32'h20);
    check_eq("oor_ch1", pat(2, 1, s, 6), 32'h10);
    check_eq("oor_ch2", pat(2, 2, s, 6), 32'h08);
    check_eq("oor_running", 32'(run3_log[s]), 32'h7);

    // One-shot P=3 on ch1
    load_valid = 1'b1; load_ch = 1'b1; load_period = 8'd3; load_oneshot = 1'b1;
    cyc(1);
    load_valid = 1'b0;
    start[1] = 1'b1;
    s = ecount + 1;
    cyc(1);
    start[1] = 1'b0;
    cyc(23);
    check_eq("oneshot_tick", pat(0, 1, s, 24), 32'h8);
    check_eq("oneshot_running", pat(1, 1, s, 8), 32'h07);

    // Mid-count reload on ch0: 5 then 2
    load_valid = 1'b1; load_ch = 1'b0; load_period = 8'd5; load_oneshot = 1'b0;
    cyc(1);
    load_valid = 1'b0;
    start[0] = 1'b1;
    s = ecount + 1;
    cyc(1);
    start[0] = 1'b0;
    cyc(1);
    load_valid = 1'b1; load_period = 8'd2;
    cyc(1);
    load_valid = 1'b0;
    cyc(12);
    check_eq("midload_tick", pat(0, 0, s, 13), 32'h0AA0);

    // Start and stop together: stop wins
    start[0] = 1'b1; stop[0] = 1'b1;
    s = ecount + 1;
    cyc(1);
    start[0] = 1'b0; stop[0] = 1'b0;
    cyc(5);
    check_eq("startstop_running", 32'(run_log[s][0]), 32'h0);
    check_eq("startstop_tick", pat(0, 0, s, 5), 32'h0);

    // Load P=7 and start on the same edge
    load_valid = 1'b1; load_ch = 1'b0; load_period = 8'd7; load_oneshot = 1'b0; start[0] = 1'b1;
    s = ecount + 1;
    cyc(1);
    load_valid = 1'b0; start[0] = 1'b0;
    cyc(9);
    check_eq("loadstart_tick", pat(0, 0, s, 9), 32'h080);

    // P=0 gives a continuous tick; stop clears it on the next edge
    load_valid = 1'b1; load_ch = 1'b0; load_period = 8'd0; start[0] = 1'b1;
    s = ecount + 1;
    cyc(1);
    load_valid = 1'b0; start[0] = 1'b0;
    cyc(6);
    check_eq("p0_tick", pat(0, 0, s, 6), 32'h3E);
    stop[0] = 1'b1;
    t = ecount + 1;
    cyc(1);
    stop[0] = 1'b0;
    cyc(2);
    check_eq("stop_tick", pat(0, 0, t - 1, 3), 32'h1);
    check_eq("stop_running", 32'(run_log[t][0]), 32'h0);

    // Asynchronous reset between edges while ticking
    start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    cyc(3);
    check_eq("pre_reset_tick", 32'(tick[0]), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_tick", 32'(tick), 32'h0);
    check_eq("async_running", 32'(running), 32'h3);
    check_eq("async_running3", 32'(running3), 32'h0);
    cyc(1);
    reset = 1'b0;
    e0 = ecount;
    cyc(16);
    check_eq("rereset_ch0", pat(0, 0, e0, 16), 32'h1110);
    check_eq("rereset_ch1", pat(0, 1, e0, 16), 32'h1040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
